// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: controller states and default operand width.
package arith_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: conditionally add M into {C,A}, then shift {C,A,Q} right by one.
module mult_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             c_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;

  always_comb begin
    addend = q_i[0] ? {1'b0, m_i} : '0;
    sum    = {c_i, a_i} + addend;
    // Carry lands in A's MSB; A's LSB moves into Q's MSB.
    a_o    = sum[WIDTH:1];
    q_o    = {sum[0], q_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier, one partial product per clock, valid/ready handshakes.
module seq_multiplier
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               src_valid,
  output logic               src_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               dest_valid,
  input  logic               dest_ready
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   a_step;
  logic [WIDTH-1:0]   q_step;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .a_i (a_q),
    .c_i (c_q),
    .q_i (q_q),
    .m_i (m_q),
    .a_o (a_step),
    .q_o (q_step)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    c_d     = c_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (src_valid) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          c_d     = 1'b0;
          count_d = CNT_W'(WIDTH);
          state_d = CALC;
        end
      end
      CALC: begin
        // Always runs the full WIDTH iterations, even for zero operands.
        a_d     = a_step;
        q_d     = q_step;
        c_d     = 1'b0;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (dest_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      c_q     <= c_d;
      count_q <= count_d;
    end
  end

  // Outputs decode only registered state, so no input-to-output combinational path.
  assign src_ready  = (state_q == IDLE);
  assign dest_valid = (state_q == DONE);
  assign product    = {a_q, q_q};

endmodule
